// File: rtl/timer_pkg.sv
// Shared timer definitions: FSM state encoding and the common done/start pulse width.
package timer_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  localparam int PULSE_W = 1;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    START = ST_START,
    WAIT  = ST_WAIT
  } state_e;

endpackage

// File: rtl/timer_sequencer.sv
// Queues interval requests and runs them one at a time on an external timer,
// with a watchdog that aborts an interval whose tim_done never arrives.
module timer_sequencer
  import timer_pkg::*;
#(
  parameter int MAX_PENDING = 4,
  parameter int TIMEOUT     = 1024,
  parameter int CNT_W       = $clog2(MAX_PENDING + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  output logic             tim_start,
  input  logic             tim_done,
  output logic             expired,
  output logic             busy,
  output logic [CNT_W-1:0] pending,
  input  logic             clr_err,
  output logic             timeout_err
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] pending_q, pending_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic             tim_start_q, tim_start_d;
  logic             expired_q, expired_d;
  logic             timeout_err_q, timeout_err_d;
  logic             accept;
  logic             dec;
  logic             wd_hit;

  assign req_ready   = rst || (pending_q < CNT_W'(MAX_PENDING));
  assign busy        = (state_q != IDLE) || (pending_q != '0);
  assign pending     = pending_q;
  assign tim_start   = tim_start_q;
  assign expired     = expired_q;
  assign timeout_err = timeout_err_q;

  always_comb begin
    accept        = req_valid && req_ready && !rst;
    dec           = (state_q == START);
    pending_d     = pending_q;
    state_d       = state_q;
    wd_d          = wd_q;
    expired_d     = 1'b0;
    wd_hit        = 1'b0;
    timeout_err_d = timeout_err_q;

    // An accept and a launch on the same edge cancel out.
    if (accept && !dec) begin
      pending_d = pending_q + CNT_W'(1);
    end else if (!accept && dec) begin
      pending_d = pending_q - CNT_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (pending_q != '0) state_d = START;
      end
      START: begin
        state_d = WAIT;
        wd_d    = '0;
      end
      WAIT: begin
        // tim_done wins over a watchdog hit on the same edge.
        if (tim_done) begin
          expired_d = 1'b1;
          state_d   = (pending_d != '0) ? START : IDLE;
        end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
          wd_hit  = 1'b1;
          state_d = IDLE;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (wd_hit) begin
      timeout_err_d = 1'b1;
    end else if (clr_err) begin
      timeout_err_d = 1'b0;
    end

    tim_start_d = (state_d == START);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      pending_q     <= '0;
      wd_q          <= '0;
      tim_start_q   <= 1'b0;
      expired_q     <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      wd_q          <= wd_d;
      tim_start_q   <= tim_start_d;
      expired_q     <= expired_d;
      timeout_err_q <= timeout_err_d;
    end
  end

endmodule

// File: tb/tb_timer_sequencer.sv
// Directed bench for timer_sequencer: a default-timeout instance and a TIMEOUT=16 instance share stimulus.
module tb_timer_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       tim_done;
  logic       clr_err;

  logic       a_req_ready, a_tim_start, a_expired, a_busy, a_err;
  logic [2:0] a_pending;
  logic       b_req_ready, b_tim_start, b_expired, b_busy, b_err;
  logic [2:0] b_pending;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  timer_sequencer #(.MAX_PENDING(4), .TIMEOUT(1024)) dut_a (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(a_req_ready),
    .tim_start(a_tim_start), .tim_done(tim_done), .expired(a_expired),
    .busy(a_busy), .pending(a_pending), .clr_err(clr_err), .timeout_err(a_err)
  );

  timer_sequencer #(.MAX_PENDING(4), .TIMEOUT(16)) dut_b (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(b_req_ready),
    .tim_start(b_tim_start), .tim_done(tim_done), .expired(b_expired),
    .busy(b_busy), .pending(b_pending), .clr_err(clr_err), .timeout_err(b_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chkp(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = 1'b0; tim_done = 1'b0; clr_err = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic run_done(input int n);
    repeat (n - 1) tick();
    tim_done = 1'b1;
    tick();
    tim_done = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b1; tim_done = 1'b0; clr_err = 1'b0;
    #1;
    chkp("rst_pending", a_pending, 3'd0);
    chk("rst_busy", a_busy, 1'b0);
    chk("rst_tim_start", a_tim_start, 1'b0);
    chk("rst_expired", a_expired, 1'b0);
    chk("rst_err", a_err, 1'b0);
    chk("rst_req_ready", a_req_ready, 1'b1);
    tick();
    chkp("rst_ignores_req", a_pending, 3'd0);
    req_valid = 1'b0;
    rst = 1'b0;

    // single request, 101-cycle timer
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    chkp("s1_pend_after_accept", a_pending, 3'd1);
    chk("s1_no_start_yet", a_tim_start, 1'b0);
    tick();
    chk("s1_tim_start", a_tim_start, 1'b1);
    chkp("s1_pend_in_start", a_pending, 3'd1);
    tick();
    chk("s1_start_one_cycle", a_tim_start, 1'b0);
    chkp("s1_pend_in_wait", a_pending, 3'd0);
    chk("s1_busy_wait", a_busy, 1'b1);
    repeat (100) begin
      tick();
      chk("s1_no_early_expired", a_expired, 1'b0);
    end
    tim_done = 1'b1;
    tick();
    tim_done = 1'b0;
    chk("s1_expired", a_expired, 1'b1);
    chk("s1_busy_done", a_busy, 1'b0);
    chk("s1_no_restart", a_tim_start, 1'b0);
    tick();
    chk("s1_expired_one_cycle", a_expired, 1'b0);

    // back-to-back requests
    do_reset();
    req_valid = 1'b1;
    tick();
    chkp("s2_pend_e0", a_pending, 3'd1);
    tick();
    chkp("s2_pend_e1", a_pending, 3'd2);
    chk("s2_start1", a_tim_start, 1'b1);
    tick();
    req_valid = 1'b0;
    chkp("s2_accept_and_dec_same_edge", a_pending, 3'd2);
    chk("s2_start1_end", a_tim_start, 1'b0);
    run_done(3);
    chk("s2_expired1", a_expired, 1'b1);
    chk("s2_start2", a_tim_start, 1'b1);
    chkp("s2_pend_before_dec2", a_pending, 3'd2);
    tick();
    chk("s2_expired1_end", a_expired, 1'b0);
    chkp("s2_pend_dec2", a_pending, 3'd1);
    run_done(2);
    chk("s2_expired2", a_expired, 1'b1);
    chk("s2_start3", a_tim_start, 1'b1);
    tick();
    chkp("s2_pend_dec3", a_pending, 3'd0);
    chk("s2_start3_end", a_tim_start, 1'b0);
    run_done(2);
    chk("s2_expired3", a_expired, 1'b1);
    chk("s2_no_start4", a_tim_start, 1'b0);
    chk("s2_idle", a_busy, 1'b0);

    // full queue: six request cycles, five accepted
    do_reset();
    req_valid = 1'b1;
    repeat (4) tick();
    chkp("s3_pend_e3", a_pending, 3'd3);
    chk("s3_ready_e3", a_req_ready, 1'b1);
    tick();
    chkp("s3_pend_e4", a_pending, 3'd4);
    chk("s3_not_ready_full", a_req_ready, 1'b0);
    tick();
    req_valid = 1'b0;
    chkp("s3_pend_held", a_pending, 3'd4);
    chk("s3_still_not_ready", a_req_ready, 1'b0);
    for (int i = 0; i < 5; i++) begin
      run_done(2);
      chk("s3_expired", a_expired, 1'b1);
      chk("s3_next_start", a_tim_start, (i < 4));
    end
    tick();
    chk("s3_idle", a_busy, 1'b0);
    chkp("s3_pend_empty", a_pending, 3'd0);

    // watchdog timeout with TIMEOUT=16
    do_reset();
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    chk("s4_tim_start", b_tim_start, 1'b1);
    tick();
    repeat (15) begin
      tick();
      chk("s4_no_early_err", b_err, 1'b0);
    end
    tick();
    chk("s4_err_set", b_err, 1'b1);
    chk("s4_no_expired", b_expired, 1'b0);
    chk("s4_idle", b_busy, 1'b0);
    chk("s4_no_restart", b_tim_start, 1'b0);
    tick();
    chk("s4_err_sticky", b_err, 1'b1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("s4_err_cleared", b_err, 1'b0);

    // tim_done on the same edge as watchdog expiry
    do_reset();
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    repeat (15) tick();
    tim_done = 1'b1;
    tick();
    tim_done = 1'b0;
    chk("s5_expired_wins", b_expired, 1'b1);
    chk("s5_no_err", b_err, 1'b0);
    chk("s5_idle", b_busy, 1'b0);
    tick();
    chk("s5_no_err_later", b_err, 1'b0);

    // reset in WAIT with two intervals queued
    do_reset();
    req_valid = 1'b1;
    repeat (3) tick();
    req_valid = 1'b0;
    chkp("s6_pend_before_rst", a_pending, 3'd2);
    tick();
    chk("s6_busy_before_rst", a_busy, 1'b1);
    rst = 1'b1;
    tim_done = 1'b1;
    #1;
    chkp("s6_rst_pending", a_pending, 3'd0);
    chk("s6_rst_busy", a_busy, 1'b0);
    chk("s6_rst_tim_start", a_tim_start, 1'b0);
    chk("s6_rst_expired", a_expired, 1'b0);
    chk("s6_rst_err", a_err, 1'b0);
    chk("s6_rst_ready", a_req_ready, 1'b1);
    tick();
    tim_done = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tim_done = (i == 2);
      tick();
      chk("s6_no_tim_start", a_tim_start, 1'b0);
      chk("s6_no_expired", a_expired, 1'b0);
      chk("s6_stays_idle", a_busy, 1'b0);
    end
    tim_done = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
